// File: rtl/axi_lite_master_bridge_if.sv
// AXI4-Lite bus bundle between the bridge (master) and the interconnect (slave).
// Write address : awaddr, awprot, awvalid / awready
// Write data    : wdata, wstrb, wvalid / wready
// Write response: bresp, bvalid / bready
// Read address  : araddr, arprot, arvalid / arready
// Read data     : rdata, rresp, rvalid / rready
interface axi_lite_master_bridge_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// Turns a core request (address/data/strobe/control, launched by a rising
// edge on i_axi_sel) into a single outstanding AXI4-Lite transaction.
// Ports:
//   i_clk, i_rst         clock, asynchronous active-low reset
//   i_axi_addr/data      request address / write data
//   i_axi_sel            request select, rising edge launches
//   i_axi_strobe         write byte strobes
//   i_axi_control        01 write, 10 read, 00/11 no operation
//   o_rx_data            last read data (kept on timeout)
//   o_busy / o_done      transaction in flight / one-cycle completion pulse
//   o_resp / o_timeout   last BRESP/RRESP (2'b10 on timeout) / sticky timeout
//   axi                  AXI4-Lite master port
// TIMEOUT_CYCLES must be >= 2.
module axi_lite_master_bridge #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [2:0] AXI_PROT       = 3'b000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_axi_addr,
    input  logic [31:0] i_axi_data,
    input  logic        i_axi_sel,
    input  logic [3:0]  i_axi_strobe,
    input  logic [1:0]  i_axi_control,
    output logic [31:0] o_rx_data,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_resp,
    output logic        o_timeout,
    axi_lite_master_bridge_if.master axi
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        sel_q;
    logic [31:0] addr_q, data_q;
    logic [3:0]  strb_q;
    logic        awvalid_q, wvalid_q, arvalid_q;
    logic [31:0] rx_data_q;
    logic [1:0]  resp_q;
    logic        timeout_q;
    logic [15:0] cnt_q;

    logic start, is_wr, is_rd, in_bus, tmo;
    logic aw_hs, w_hs, ar_hs, wr_both;
    logic tmo_fire, b_cap, r_cap;

    assign start  = i_axi_sel & ~sel_q & (state_q == IDLE);
    assign is_wr  = (i_axi_control == 2'b01);
    assign is_rd  = (i_axi_control == 2'b10);
    assign in_bus = (state_q == WR) || (state_q == WR_RESP) ||
                    (state_q == RD_ADDR) || (state_q == RD_DATA);
    // >= rather than == so a state entered with the counter already at
    // the limit still times out instead of waiting for a wrap.
    assign tmo    = in_bus && (cnt_q >= TMO_LAST);

    assign aw_hs  = awvalid_q & axi.awready;
    assign w_hs   = wvalid_q & axi.wready;
    assign ar_hs  = arvalid_q & axi.arready;
    // Each channel is finished when its valid is already down or handshakes now.
    assign wr_both = (~awvalid_q | axi.awready) & (~wvalid_q | axi.wready);

    // Handshake progress wins over a timeout in the same cycle.
    always_comb begin
        state_d  = state_q;
        tmo_fire = 1'b0;
        b_cap    = 1'b0;
        r_cap    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && is_wr)      state_d = WR;
                else if (start && is_rd) state_d = RD_ADDR;
            end
            WR: begin
                if (wr_both)  state_d = WR_RESP;
                else if (tmo) begin state_d = DONE; tmo_fire = 1'b1; end
            end
            WR_RESP: begin
                if (axi.bvalid) begin state_d = DONE; b_cap = 1'b1; end
                else if (tmo)   begin state_d = DONE; tmo_fire = 1'b1; end
            end
            RD_ADDR: begin
                if (ar_hs)    state_d = RD_DATA;
                else if (tmo) begin state_d = DONE; tmo_fire = 1'b1; end
            end
            RD_DATA: begin
                if (axi.rvalid) begin state_d = DONE; r_cap = 1'b1; end
                else if (tmo)   begin state_d = DONE; tmo_fire = 1'b1; end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rx_data_q <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= i_axi_sel;

            if (start) begin
                addr_q    <= i_axi_addr;
                data_q    <= i_axi_data;
                strb_q    <= i_axi_strobe;
                cnt_q     <= '0;
                timeout_q <= 1'b0;
            end else if (in_bus) begin
                cnt_q <= cnt_q + 16'd1;
            end

            // AW and W retire independently, each on its own handshake.
            if (start && is_wr) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
            end else begin
                if (aw_hs || tmo_fire) awvalid_q <= 1'b0;
                if (w_hs || tmo_fire)  wvalid_q  <= 1'b0;
            end

            if (start && is_rd)        arvalid_q <= 1'b1;
            else if (ar_hs || tmo_fire) arvalid_q <= 1'b0;

            if (b_cap) resp_q <= axi.bresp;
            if (r_cap) begin
                resp_q    <= axi.rresp;
                rx_data_q <= axi.rdata;
            end
            if (tmo_fire) begin
                resp_q    <= 2'b10;
                timeout_q <= 1'b1;
            end
        end
    end

    assign axi.awaddr  = addr_q;
    assign axi.awprot  = AXI_PROT;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = data_q;
    assign axi.wstrb   = strb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = (state_q == WR_RESP);
    assign axi.araddr  = addr_q;
    assign axi.arprot  = AXI_PROT;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = (state_q == RD_DATA);

    assign o_rx_data = rx_data_q;
    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);
    assign o_resp    = resp_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Randomized bench for axi_lite_master_bridge: a delay-programmable slave on
// the main instance, a second instance with TIMEOUT_CYCLES=8 for timeouts,
// and a transaction-level model of the expected bus and core-side results.
module tb_axi_lite_master_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic [31:0] a_addr = '0, a_data = '0;
    logic        a_sel = 1'b0;
    logic [3:0]  a_strb = '0;
    logic [1:0]  a_ctrl = '0;
    logic [31:0] rx;
    logic        busy, done, to;
    logic [1:0]  resp;

    axi_lite_master_bridge_if bus();

    axi_lite_master_bridge dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_axi_addr(a_addr), .i_axi_data(a_data), .i_axi_sel(a_sel),
        .i_axi_strobe(a_strb), .i_axi_control(a_ctrl),
        .o_rx_data(rx), .o_busy(busy), .o_done(done), .o_resp(resp),
        .o_timeout(to), .axi(bus)
    );

    // ---------------- timeout instance ----------------
    logic [31:0] b_addr = '0, b_data = '0;
    logic        b_sel = 1'b0;
    logic [3:0]  b_strb = '0;
    logic [1:0]  b_ctrl = '0;
    logic [31:0] rx8;
    logic        busy8, done8, to8;
    logic [1:0]  resp8;
    logic        ar_en8 = 1'b1;

    axi_lite_master_bridge_if bus8();

    axi_lite_master_bridge #(.TIMEOUT_CYCLES(8)) dut8 (
        .i_clk(clk), .i_rst(rst_n),
        .i_axi_addr(b_addr), .i_axi_data(b_data), .i_axi_sel(b_sel),
        .i_axi_strobe(b_strb), .i_axi_control(b_ctrl),
        .o_rx_data(rx8), .o_busy(busy8), .o_done(done8), .o_resp(resp8),
        .o_timeout(to8), .axi(bus8)
    );

    // Always-willing slave; arready gated to force a timeout.
    assign bus8.awready = 1'b1;
    assign bus8.wready  = 1'b1;
    assign bus8.bvalid  = 1'b1;
    assign bus8.bresp   = 2'b00;
    assign bus8.arready = ar_en8;
    assign bus8.rvalid  = 1'b1;
    assign bus8.rresp   = 2'b00;
    assign bus8.rdata   = 32'hCAFE_F00D;

    // ---------------- programmable slave for main instance ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  bresp_v = '0, rresp_v = '0;
    logic [31:0] rdata_v = '0;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic        aw_hs, w_hs, ar_hs;

    assign bus.awready = bus.awvalid && (aw_cnt >= aw_dly);
    assign bus.wready  = bus.wvalid  && (w_cnt  >= w_dly);
    assign bus.arready = bus.arvalid && (ar_cnt >= ar_dly);
    assign bus.bvalid  = b_pend && (b_cnt >= b_dly);
    assign bus.rvalid  = r_pend && (r_cnt >= r_dly);
    assign bus.bresp   = bresp_v;
    assign bus.rresp   = rresp_v;
    assign bus.rdata   = rdata_v;
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid  && bus.wready;
    assign ar_hs = bus.arvalid && bus.arready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            aw_cnt <= bus.awvalid ? aw_cnt + 1 : 0;
            w_cnt  <= bus.wvalid  ? w_cnt + 1  : 0;
            ar_cnt <= bus.arvalid ? ar_cnt + 1 : 0;
            if (b_pend) begin
                if (bus.bvalid && bus.bready) b_pend <= 1'b0;
                else b_cnt <= b_cnt + 1;
            end else if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (r_pend) begin
                if (bus.rvalid && bus.rready) r_pend <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end else if (ar_hs) begin
                r_pend <= 1'b1; r_cnt <= 0;
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [31:0] aw_q[$], ar_q[$];
    logic [35:0] w_q[$];
    int cyc = 0, aw_cyc = 0, w_cyc = 0;
    int done_cnt = 0, aw_hi = 0, w_hi = 0, done8_cnt = 0, ar8_hi = 0;
    int bready_early = 0, unstable = 0, drop_bad = 0, double_done = 0, prot_bad = 0;
    logic        done_p = 1'b0, awv_p = 1'b0, wv_p = 1'b0, arv_p = 1'b0;
    logic        awh_p = 1'b0, wh_p = 1'b0, arh_p = 1'b0;
    logic [31:0] awa_p = '0, wd_p = '0, ara_p = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (aw_hs) begin
            aw_q.push_back(bus.awaddr); aw_cyc <= cyc;
            if (bus.awprot != 3'b000) prot_bad <= prot_bad + 1;
        end
        if (w_hs) begin
            w_q.push_back({bus.wstrb, bus.wdata}); w_cyc <= cyc;
        end
        if (ar_hs) begin
            ar_q.push_back(bus.araddr);
            if (bus.arprot != 3'b000) prot_bad <= prot_bad + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (done && done_p) double_done <= double_done + 1;
        if (bus.awvalid) aw_hi <= aw_hi + 1;
        if (bus.wvalid)  w_hi  <= w_hi + 1;
        if (bus.bready && (bus.awvalid || bus.wvalid)) bready_early <= bready_early + 1;
        if (rst_n) begin
            if ((awv_p && !awh_p && (!bus.awvalid || bus.awaddr != awa_p)) ||
                (wv_p  && !wh_p  && (!bus.wvalid  || bus.wdata  != wd_p))  ||
                (arv_p && !arh_p && (!bus.arvalid || bus.araddr != ara_p)))
                drop_bad <= drop_bad + 1;
        end
        done_p <= done;
        awv_p <= bus.awvalid; wv_p <= bus.wvalid; arv_p <= bus.arvalid;
        awh_p <= aw_hs; wh_p <= w_hs; arh_p <= ar_hs;
        awa_p <= bus.awaddr; wd_p <= bus.wdata; ara_p <= bus.araddr;
        if (done8) done8_cnt <= done8_cnt + 1;
        if (bus8.arvalid) ar8_hi <= ar8_hi + 1;
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level model of the core-visible results.
    logic [31:0] m_rx = '0;
    logic [1:0]  m_resp = '0;
    logic        m_to = 1'b0;

    // One request on the main instance; hold = cycles sel stays high,
    // mid_pulse re-raises sel while the transaction is still in flight.
    task automatic run_txn(input logic [1:0] ctrl, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input int hold, input bit mid_pulse);
        int d0, aw0, w0, ar0, k;
        bit is_wr, is_rd;
        is_wr = (ctrl == 2'b01);
        is_rd = (ctrl == 2'b10);
        d0 = done_cnt; aw0 = aw_q.size(); w0 = w_q.size(); ar0 = ar_q.size();
        @(negedge clk);
        a_addr = addr; a_data = data; a_strb = strb; a_ctrl = ctrl; a_sel = 1'b1;
        repeat (hold) @(negedge clk);
        a_sel = 1'b0;
        if (mid_pulse) begin
            repeat (3) @(negedge clk);
            a_ctrl = 2'b01; a_sel = 1'b1;
            @(negedge clk);
            a_sel = 1'b0;
        end
        if (is_wr || is_rd) begin
            k = 0;
            while (done_cnt == d0 && k < 200) begin @(negedge clk); k++; end
            chk("done_in_time", 64'(k < 200), 64'd1);
        end
        repeat (6) @(negedge clk);

        if (is_wr) begin m_resp = bresp_v; m_to = 1'b0; end
        else if (is_rd) begin m_rx = rdata_v; m_resp = rresp_v; m_to = 1'b0; end

        chk("done_pulses", 64'(done_cnt - d0), (is_wr || is_rd) ? 64'd1 : 64'd0);
        chk("aw_count", 64'(aw_q.size() - aw0), is_wr ? 64'd1 : 64'd0);
        chk("w_count",  64'(w_q.size() - w0),   is_wr ? 64'd1 : 64'd0);
        chk("ar_count", 64'(ar_q.size() - ar0), is_rd ? 64'd1 : 64'd0);
        if (is_wr && aw_q.size() > aw0) chk("awaddr", aw_q[aw0], addr);
        if (is_wr && w_q.size() > w0)   chk("wdata_wstrb", w_q[w0], {strb, data});
        if (is_rd && ar_q.size() > ar0) chk("araddr", ar_q[ar0], addr);
        chk("rx_data", rx, m_rx);
        chk("resp", resp, m_resp);
        chk("timeout", to, m_to);
        chk("busy_after", busy, 1'b0);
    endtask

    task automatic run8(input logic [1:0] ctrl);
        int d0, k;
        d0 = done8_cnt;
        @(negedge clk);
        b_addr = 32'h3000_0040; b_data = 32'h0BAD_F00D; b_strb = 4'h3; b_ctrl = ctrl; b_sel = 1'b1;
        @(negedge clk);
        b_sel = 1'b0;
        k = 0;
        while (done8_cnt == d0 && k < 40) begin @(negedge clk); k++; end
        chk("t8_done_in_time", 64'(k < 40), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int h0, d0, k, h1, w1;
        // Reset state
        #12;
        chk("rst_outputs", {rx, resp, busy, done, to}, 37'd0);
        chk("rst_bus", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait write
        aw_dly = 0; w_dly = 0; b_dly = 0; bresp_v = 2'b00;
        run_txn(2'b01, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1, 1'b0);
        chk("aw_w_same_cycle", 64'(aw_cyc - w_cyc), 64'd0);

        // Staggered write: awvalid held 3 cycles, wvalid 1 cycle
        aw_dly = 2; w_dly = 0; b_dly = 1; bresp_v = 2'b01;
        h1 = aw_hi; w1 = w_hi;
        run_txn(2'b01, 32'h1000_0020, 32'h0102_0304, 4'h5, 1, 1'b0);
        chk("aw_valid_cycles", 64'(aw_hi - h1), 64'd3);
        chk("w_valid_cycles", 64'(w_hi - w1), 64'd1);

        // Read, plus a sel edge mid-transaction that must be ignored
        ar_dly = 2; r_dly = 5; rdata_v = 32'h1234_5678; rresp_v = 2'b00;
        run_txn(2'b10, 32'h2000_0000, 32'hFFFF_FFFF, 4'hF, 1, 1'b1);

        // Error read still updates rx_data
        ar_dly = 0; r_dly = 1; rdata_v = 32'hA5A5_0001; rresp_v = 2'b10;
        run_txn(2'b10, 32'h2000_0004, 32'h0, 4'h0, 1, 1'b0);

        // Sel held high across a completed write
        aw_dly = 0; w_dly = 1; b_dly = 0; bresp_v = 2'b00;
        run_txn(2'b01, 32'h1000_0030, 32'h5555_AAAA, 4'hC, 20, 1'b0);

        // No-op controls
        run_txn(2'b00, 32'h1000_0040, 32'h1, 4'h1, 1, 1'b0);
        run_txn(2'b11, 32'h1000_0044, 32'h2, 4'h2, 1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            bresp_v = 2'($urandom); rresp_v = 2'($urandom); rdata_v = $urandom;
            run_txn(2'($urandom), $urandom, $urandom, 4'($urandom),
                    $urandom_range(1, 3), 1'b0);
        end

        // Timeout instance: good read, timed-out read, clearing write
        ar_en8 = 1'b1;
        run8(2'b10);
        chk("t8_rx_first", rx8, 32'hCAFE_F00D);
        chk("t8_resp_first", resp8, 2'b00);
        ar_en8 = 1'b0;
        h0 = ar8_hi;
        run8(2'b10);
        chk("t8_arvalid_cycles", 64'(ar8_hi - h0), 64'd8);
        chk("t8_arvalid_low", bus8.arvalid, 1'b0);
        chk("t8_resp_timeout", resp8, 2'b10);
        chk("t8_timeout_flag", to8, 1'b1);
        chk("t8_rx_kept", rx8, 32'hCAFE_F00D);
        chk("t8_busy", busy8, 1'b0);
        ar_en8 = 1'b1;
        run8(2'b01);
        chk("t8_timeout_cleared", to8, 1'b0);
        chk("t8_resp_write", resp8, 2'b00);

        // Reset while waiting in the read data phase
        ar_dly = 0; r_dly = 40;
        @(negedge clk);
        a_ctrl = 2'b10; a_addr = 32'h2000_0100; a_sel = 1'b1;
        @(negedge clk);
        a_sel = 1'b0;
        k = 0;
        while (!bus.rready && k < 20) begin @(negedge clk); k++; end
        chk("rd_data_reached", bus.rready, 1'b1);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bus", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'd0);
        chk("async_rst_core", {busy, done, rx, resp, to}, 37'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_done_on_reset", 64'(done_cnt - d0), 64'd0);
        m_rx = '0; m_resp = '0; m_to = 1'b0;
        ar_dly = 1; r_dly = 2; rdata_v = 32'h7777_0123; rresp_v = 2'b00;
        run_txn(2'b10, 32'h2000_0200, 32'h0, 4'h0, 1, 1'b0);

        // Protocol invariants over the whole run
        chk("bready_before_both_hs", 64'(bready_early), 64'd0);
        chk("valid_dropped_or_changed", 64'(drop_bad), 64'd0);
        chk("done_wider_than_1", 64'(double_done), 64'd0);
        chk("prot_nonzero", 64'(prot_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Hard stop so a hung DUT still produces a summary line.
    initial begin
        #500000;
        n_err++;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
